// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: command front-end for a combinational 4-bit ALU.
// Commands are queued in a DEPTH-entry FIFO, issued one at a time to the
// ALU, held for SETTLE cycles, captured, and returned in order on a
// valid/ready response channel.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready     command request handshake (ready = FIFO not full)
//   cmd_opcode/a/b      command payload
//   cmd_use_acc         take operand A from the accumulator (ALU_ACCUM_EN)
//   alu_opcode/A/B      registered drive to the ALU
//   alu_result/carry    ALU outputs, sampled at capture
//   rsp_valid/ready     response handshake
//   rsp_result/carry/opcode  captured response payload
//   busy                state not IDLE or FIFO non-empty
//
// Build option: define ALU_ACCUM_EN to add the 8-bit result accumulator.
module alu_issue_ctrl #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_opcode,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   input  logic       cmd_use_acc,
   output logic [2:0] alu_opcode,
   output logic [3:0] alu_A,
   output logic [3:0] alu_B,
   input  logic [7:0] alu_result,
   input  logic       alu_carry,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_result,
   output logic       rsp_carry,
   output logic [2:0] rsp_opcode,
   output logic       busy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // ---------------- command FIFO ----------------
   logic [2:0]       mem_op_q [DEPTH];
   logic [3:0]       mem_a_q  [DEPTH];
   logic [3:0]       mem_b_q  [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             full_c, empty_c, push_c, pop_c;

   assign full_c    = (count_q == CNT_W'(DEPTH));
   assign empty_c   = (count_q == '0);
   assign cmd_ready = !full_c;
   assign push_c    = cmd_valid && !full_c;

`ifdef ALU_ACCUM_EN
   logic mem_use_q [DEPTH];
   logic [7:0] acc_q, acc_d;
`else
   logic unused_use_acc;
   assign unused_use_acc = cmd_use_acc;
`endif

   // Payload storage needs no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_op_q[wr_ptr_q] <= cmd_opcode;
         mem_a_q[wr_ptr_q]  <= cmd_a;
         mem_b_q[wr_ptr_q]  <= cmd_b;
`ifdef ALU_ACCUM_EN
         mem_use_q[wr_ptr_q] <= cmd_use_acc;
`endif
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_c, pop_c})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Operand A as issued: accumulator low nibble when requested.
   logic [3:0] head_a_c;
`ifdef ALU_ACCUM_EN
   assign head_a_c = mem_use_q[rd_ptr_q] ? acc_q[3:0] : mem_a_q[rd_ptr_q];
`else
   assign head_a_c = mem_a_q[rd_ptr_q];
`endif

   // ---------------- issue FSM ----------------
   state_t           state_q, state_d;
   logic [SET_W-1:0] set_q, set_d;
   logic [2:0]       alu_op_q, alu_op_d;
   logic [3:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [7:0]       rsp_result_q, rsp_result_d;
   logic             rsp_carry_q, rsp_carry_d;
   logic [2:0]       rsp_op_q, rsp_op_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         set_q        <= '0;
         alu_op_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_carry_q  <= 1'b0;
         rsp_op_q     <= '0;
`ifdef ALU_ACCUM_EN
         acc_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         set_q        <= set_d;
         alu_op_q     <= alu_op_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_carry_q  <= rsp_carry_d;
         rsp_op_q     <= rsp_op_d;
`ifdef ALU_ACCUM_EN
         acc_q        <= acc_d;
`endif
      end
   end

   // Next-state: pop into the ALU drive regs, settle, capture, hand off.
   always_comb begin
      state_d      = state_q;
      set_d        = set_q;
      alu_op_d     = alu_op_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_carry_d  = rsp_carry_q;
      rsp_op_d     = rsp_op_q;
      pop_c        = 1'b0;
`ifdef ALU_ACCUM_EN
      acc_d        = acc_q;
`endif
      case (state_q)
         IDLE: begin
            if (!empty_c) begin
               pop_c   = 1'b1;
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            if (set_q == SET_W'(SETTLE - 1)) begin
               rsp_valid_d  = 1'b1;
               rsp_result_d = alu_result;
               rsp_carry_d  = alu_carry;
               rsp_op_d     = alu_op_q;
`ifdef ALU_ACCUM_EN
               acc_d        = alu_result;
`endif
               state_d      = RESP;
            end else begin
               set_d = set_q + SET_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (!empty_c) begin
                  pop_c   = 1'b1;
                  state_d = DRIVE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (pop_c) begin
         alu_op_d = mem_op_q[rd_ptr_q];
         alu_a_d  = head_a_c;
         alu_b_d  = mem_b_q[rd_ptr_q];
         set_d    = '0;
      end
   end

   assign alu_opcode = alu_op_q;
   assign alu_A      = alu_a_q;
   assign alu_B      = alu_b_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_carry  = rsp_carry_q;
   assign rsp_opcode = rsp_op_q;
   assign busy       = (state_q != IDLE) || !empty_c;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: an in-bench ALU stand-in, a
// queue-based reference model compared every cycle, directed scenarios
// with literal expectations, and a randomized traffic phase.
module tb_alu_issue_ctrl;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned SETTLE = 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready, cmd_use_acc;
   logic [2:0] cmd_opcode;
   logic [3:0] cmd_a, cmd_b;
   logic [2:0] alu_opcode;
   logic [3:0] alu_A, alu_B;
   logic [7:0] alu_result;
   logic       alu_carry;
   logic       rsp_valid, rsp_ready, rsp_carry;
   logic [7:0] rsp_result;
   logic [2:0] rsp_opcode;
   logic       busy;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .cmd_use_acc(cmd_use_acc),
      .alu_opcode(alu_opcode), .alu_A(alu_A), .alu_B(alu_B),
      .alu_result(alu_result), .alu_carry(alu_carry),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_carry(rsp_carry),
      .rsp_opcode(rsp_opcode), .busy(busy)
   );

   // Behavioural stand-in for the combinational ALU: {carry, result}.
   function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      logic [4:0] s;
      logic [7:0] r;
      logic       c;
      r = 8'h00;
      c = 1'b0;
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b}; r = {4'h0, s[3:0]}; c = s[4]; end
         3'd1: begin s = {1'b0, a} - {1'b0, b}; r = {4'h0, s[3:0]}; c = s[4]; end
         3'd2: r = 8'(a) * 8'(b);
         3'd3: begin
            if (b == 4'd0) begin r = 8'hFF; c = 1'b1; end
            else r = 8'(a / b);
         end
         3'd4: r = {4'h0, ~(a & b)};
         3'd5: r = {4'h0, ~a};
         3'd6: r = {6'b0, (a == b), (a > b)};
         default: begin s = {1'b0, a} + {1'b0, b}; r = {4'h0, s[4:1]}; end
      endcase
      return {c, r};
   endfunction

   logic [8:0] alu_out;
   assign alu_out    = alu_f(alu_opcode, alu_A, alu_B);
   assign alu_result = alu_out[7:0];
   assign alu_carry  = alu_out[8];

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [2:0] op;
      logic [3:0] a_eff;
      logic [7:0] res;
      logic       c;
   } exp_t;

   exp_t       exp_q[$];
   int         outstanding = 0;
   logic [7:0] m_acc = 8'h00;
   int         n_rsp = 0;
   logic [7:0] log_res[$];
   logic [3:0] log_a[$];
   int         log_cyc[$];
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic       prev_stall = 1'b0;
   logic [11:0] prev_rsp = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare on the falling edge, then record what the next rising edge does.
   always @(negedge clk) begin
      exp_t       e;
      logic [8:0] r;
      logic [3:0] a_eff;
      if (!rst_n) begin
         exp_q.delete();
         outstanding = 0;
         m_acc       = 8'h00;
         prev_stall  = 1'b0;
         chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
         chk("rst_alu", 32'({alu_opcode, alu_A, alu_B}), 32'd0);
         chk("rst_rsp", 32'({rsp_carry, rsp_opcode, rsp_result}), 32'd0);
      end else begin
         chk("cmd_ready", 32'(cmd_ready), 32'(outstanding != int'(DEPTH) + 1));
         chk("busy", 32'(busy), 32'(outstanding != 0));
         if (prev_stall)
            chk("rsp_hold", 32'({rsp_valid, rsp_carry, rsp_opcode, rsp_result}), 32'({1'b1, prev_rsp}));
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("rsp_spurious", 32'(rsp_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_result", 32'(rsp_result), 32'(e.res));
               chk("rsp_carry", 32'(rsp_carry), 32'(e.c));
               chk("rsp_opcode", 32'(rsp_opcode), 32'(e.op));
               chk("alu_A_issued", 32'(alu_A), 32'(e.a_eff));
               log_res.push_back(rsp_result);
               log_a.push_back(alu_A);
               log_cyc.push_back(cyc);
               n_rsp++;
               outstanding--;
            end
         end
         prev_stall = rsp_valid && !rsp_ready;
         prev_rsp   = {rsp_carry, rsp_opcode, rsp_result};
         if (cmd_valid && cmd_ready) begin
            a_eff = cmd_a;
`ifdef ALU_ACCUM_EN
            if (cmd_use_acc) a_eff = m_acc[3:0];
`endif
            r = alu_f(cmd_opcode, a_eff, cmd_b);
            m_acc = r[7:0];
            e = '{op: cmd_opcode, a_eff: a_eff, res: r[7:0], c: r[8]};
            exp_q.push_back(e);
            outstanding++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic ua);
      bit done;
      done       = 1'b0;
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      cmd_use_acc = ua;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (cmd_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      if (!done) chk("send_timeout", 32'(done), 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      int i;
      i = 0;
      while ((outstanding != 0) && (i < budget)) begin
         @(posedge clk);
         #1;
         i++;
      end
      if (outstanding != 0) chk("drain_timeout", 32'(outstanding), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, rn, base;
      rst_n = 1'b1;
      cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_use_acc = 1'b0;
      rsp_ready = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("reset_alu", 32'({alu_opcode, alu_A, alu_B}), 32'd0);

      // Single ADD 9+8 with latency checks.
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_opcode = 3'd0; cmd_a = 4'd9; cmd_b = 4'd8; cmd_use_acc = 1'b0;
      @(posedge clk); #1;                    // accept edge N
      cmd_valid = 1'b0;
      chk("add_no_drive_yet", 32'(alu_A), 32'd0);
      @(posedge clk); #1;                    // N+1: pop and drive
      chk("add_alu_A", 32'(alu_A), 32'd9);
      chk("add_alu_B", 32'(alu_B), 32'd8);
      chk("add_alu_op", 32'(alu_opcode), 32'd0);
      chk("add_rsp_valid_early", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;                    // N+2: captured
      chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("add_rsp_result", 32'(rsp_result), 32'h01);
      chk("add_rsp_carry", 32'(rsp_carry), 32'd1);
      chk("add_rsp_opcode", 32'(rsp_opcode), 32'd0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("add_rsp_cleared", 32'(rsp_valid), 32'd0);

      // Backpressure: offer 6, expect 5 accepted.
      k = 0;
      for (int c = 0; c < 8; c++) begin
         if (k < 6) begin
            cmd_valid = 1'b1; cmd_opcode = 3'(k); cmd_a = 4'(k + 5); cmd_b = 4'(k + 1);
         end else begin
            cmd_valid = 1'b0;
         end
         @(negedge clk);
         if (cmd_valid && cmd_ready) k++;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      chk("bp_accepted", 32'(k), 32'd5);
      chk("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
      rn = n_rsp;
      rsp_ready = 1'b1;
      wait_idle(100);
      rsp_ready = 1'b0;
      chk("bp_rsp_count", 32'(n_rsp - rn), 32'd5);
      chk("bp_cmd_ready_back", 32'(cmd_ready), 32'd1);

      // Streaming MUL then DIV.
      base = log_res.size();
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_opcode = 3'd2; cmd_a = 4'd15; cmd_b = 4'd15;
      @(posedge clk); #1;
      cmd_opcode = 3'd3; cmd_a = 4'd12; cmd_b = 4'd3;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wait_idle(50);
      if (log_res.size() < base + 2) begin
         chk("stream_count", 32'(log_res.size()), 32'(base + 2));
      end else begin
         chk("stream_mul", 32'(log_res[base]), 32'hE1);
         chk("stream_div", 32'(log_res[base + 1]), 32'h04);
         chk("stream_spacing", 32'(log_cyc[base + 1] - log_cyc[base]), 32'(SETTLE + 1));
      end

      // Accumulator chaining.
      base = log_res.size();
      send(3'd0, 4'd3, 4'd4, 1'b0);
      send(3'd0, 4'd0, 4'd2, 1'b1);
      wait_idle(50);
      if (log_res.size() < base + 2) begin
         chk("acc_count", 32'(log_res.size()), 32'(base + 2));
      end else begin
         chk("acc_first", 32'(log_res[base]), 32'h07);
`ifdef ALU_ACCUM_EN
         chk("acc_alu_A", 32'(log_a[base + 1]), 32'd7);
         chk("acc_result", 32'(log_res[base + 1]), 32'h09);
`else
         chk("acc_alu_A", 32'(log_a[base + 1]), 32'd0);
         chk("acc_result", 32'(log_res[base + 1]), 32'h02);
`endif
      end

      // Reset mid-DRIVE with two entries queued.
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(3'd0, 4'(i), 4'(i), 1'b0);
      repeat (2) @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("mid_busy_before", 32'(busy), 32'd1);
      chk("mid_queued", 32'(outstanding), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      rn = n_rsp;
      rsp_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("post_rst_no_rsp", 32'(n_rsp - rn), 32'd0);
      chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);

      // Randomized traffic.
      for (int c = 0; c < 800; c++) begin
         cmd_valid   = ($urandom_range(2) != 0);
         cmd_opcode  = 3'($urandom_range(7));
         cmd_a       = 4'($urandom_range(15));
         cmd_b       = 4'($urandom_range(15));
         cmd_use_acc = 1'($urandom_range(1));
         rsp_ready   = ($urandom_range(3) != 0);
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_idle(200);
      chk("final_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
